// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 target, MSB first, fixed DATA_W-bit frames, oversampled on clk
//   clk, rst            system clock, async active-high reset
//   sclk, cs_n, mosi    raw pad inputs from the master (asynchronous to clk)
//   miso, miso_oe       serial data to the master and its pad enable
//   tx_data, tx_load    host word and load strobe; tx_ready = holding register empty
//   rx_data, rx_valid   last complete frame and its one-clk update pulse
//   busy, abort         mid-frame flag; pulse when cs_n rises on a partial frame
module spi_slave #(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_WORD   = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              abort
);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] sclk_sr, cs_sr, mosi_sr;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic                   frame_start, rx_sample, tx_shift, end_sel;
    logic [DATA_W-1:0]      tx_buf, tx_sr, rx_sr;
    logic [CW-1:0]          bit_cnt;
    logic                   frame_end;

    assign sclk_s    = sclk_sr[SYNC_STAGES-1];
    assign cs_s      = cs_sr[SYNC_STAGES-1];
    assign mosi_s    = mosi_sr[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sr <= '0;
            cs_sr   <= '1;
            mosi_sr <= '0;
            sclk_d  <= 1'b0;
            cs_d    <= 1'b1;
        end else begin
            sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
            cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs_n};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
            sclk_d  <= sclk_s;
            cs_d    <= cs_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // cs_rise outranks any sclk edge in the same cycle, so that edge is never sampled
    always_comb begin
        state_nx    = (state == IDLE) ? (cs_fall ? ACTIVE : IDLE) : (cs_rise ? IDLE : ACTIVE);
        end_sel     = (state == ACTIVE) && cs_rise;
        frame_start = ((state == IDLE) && cs_fall) || ((state == ACTIVE) && !cs_rise && sclk_fall && frame_end);
        rx_sample   = (state == ACTIVE) && !cs_rise && sclk_rise;
        tx_shift    = (state == ACTIVE) && !cs_rise && sclk_fall && !frame_end;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_buf    <= '0;
            tx_ready  <= 1'b1;
            tx_sr     <= '0;
            rx_sr     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            abort     <= 1'b0;
            bit_cnt   <= '0;
            frame_end <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            abort    <= 1'b0;
            // a load coinciding with a frame start lands in tx_buf for the following frame
            if (tx_load && tx_ready) begin
                tx_buf   <= tx_data;
                tx_ready <= 1'b0;
            end else if (frame_start) begin
                tx_ready <= 1'b1;
            end
            if (end_sel) begin
                abort     <= bit_cnt != '0;
                bit_cnt   <= '0;
                frame_end <= 1'b0;
            end else if (frame_start) begin
                tx_sr     <= tx_ready ? IDLE_WORD : tx_buf;
                bit_cnt   <= '0;
                frame_end <= 1'b0;
            end else if (rx_sample) begin
                rx_sr <= {rx_sr[DATA_W-2:0], mosi_s};
                if (bit_cnt == CW'(DATA_W - 1)) begin
                    rx_data   <= {rx_sr[DATA_W-2:0], mosi_s};
                    rx_valid  <= 1'b1;
                    bit_cnt   <= '0;
                    frame_end <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end else if (tx_shift) begin
                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign miso_oe = state == ACTIVE;
    assign miso    = (state == ACTIVE) & tx_sr[DATA_W-1];
    assign busy    = (state == ACTIVE) && (bit_cnt != '0);
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI mode-0 target (CPOL=0, CPHA=0), MSB first, with a fixed DATA_W-bit frame. It is the responder at the far end of the link from the team's SPI master.
- It oversamples the external sclk, cs_n and mosi on the system clk and deserialises mosi into rx_data, pulsing rx_valid per frame.
- It serialises a host-loaded tx byte onto miso.
- It sits between the pad ring and the register/command logic of a peripheral.

Parameters:
- DATA_W, 8: frame width in bits (>= 2).
- SYNC_STAGES, 2: flops in each input synchroniser (>= 2).
- IDLE_WORD, 8'hFF: word sent when no fresh tx_data is pending at frame start; width DATA_W.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- sclk  in  1  SPI clock from master, asynchronous to clk.
- cs_n  in  1  chip select from master, active-low, asynchronous.
- mosi  in  1  serial data from master.
- miso  out  1  serial data to master; 0 when not selected.
- miso_oe  out  1  pad output enable; equals the selected state.
- tx_data  in  DATA_W  word to transmit.
- tx_load  in  1  host strobe; captures tx_data when tx_ready=1.
- tx_ready  out  1  tx holding register empty.
- rx_data  out  DATA_W  last complete received frame.
- rx_valid  out  1  one-clk pulse when rx_data is updated.
- busy  out  1  selected and mid-frame (bit_cnt != 0).
- abort  out  1  one-clk pulse when cs_n rises with a partial frame.

Behaviour:
- Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, abort=0. Synchroniser flops reset to sclk=0, cs_n=1, mosi=0. bit_cnt=0; state IDLE.
- Synchronisation:
  - sclk, cs_n and mosi each pass through SYNC_STAGES flops.
  - Edges come from the synchronised value vs. a one-cycle-delayed copy: sclk_rise, sclk_fall, cs_fall, cs_rise.
  - Each sclk high and low phase must last >= SYNC_STAGES+2 clk. Shorter phases are out of scope.
- TX holding register:
  - tx_load with tx_ready=1: tx_buf <= tx_data, tx_ready <= 0.
  - tx_load with tx_ready=0: ignored, tx_buf unchanged.
  - At each frame start the shift register loads tx_buf if tx_ready=0 and sets tx_ready <= 1. Otherwise it loads IDLE_WORD.
  - If tx_load and a frame-start load fall on the same cycle, the frame takes the old tx_buf (or IDLE_WORD), and the new word is captured for the next frame.
- FSM states:
  - IDLE -> ACTIVE on cs_fall. Frame start: load tx shift register, miso = its MSB, miso_oe=1, bit_cnt=0.
  - ACTIVE, sclk_rise:
    - rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync} and bit_cnt++.
    - If bit_cnt == DATA_W-1: rx_data <= completed word, rx_valid=1 next cycle, bit_cnt <= 0, frame_end flag set.
  - ACTIVE, sclk_fall:
    - If frame_end is set: new frame start (back-to-back, cs_n held low), clear frame_end.
    - Otherwise shift tx left by one and drive the new MSB on miso.
  - ACTIVE -> IDLE on cs_rise. miso=0, miso_oe=0.
    - If bit_cnt != 0: abort pulse, partial rx discarded, no rx_valid. rx_data is unchanged.
    - A tx word already moved to the shift register is consumed and not retransmitted.
- Edge cases:
  - cs_rise and sclk_rise in the same clk: cs_rise wins; that edge is not sampled.
  - sclk edges while in IDLE: ignored.
- busy = ACTIVE && bit_cnt != 0.
- rx_valid is a pulse; no backpressure. The host must read rx_data within one frame time.
- rst mid-frame: immediate return to reset values. The partial frame and any pending tx_buf are lost.

Test Plan:
- Single frame: tx_load 8'hA5; master sends 8'h3C, cs_n low, 8 sclk cycles of 10 clk period -> miso bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; exactly one rx_valid; tx_ready returns 1 at frame start.
- Back-to-back: load 8'h11, start frame, load 8'h22 during the frame; master sends 8'h81 then 8'h7E with cs_n held low -> miso 8'h11 then 8'h22; two rx_valid pulses with 8'h81, 8'h7E.
- Underrun: no tx_load before frame; master sends 8'h00 -> miso shifts 8'hFF (IDLE_WORD); rx_data=8'h00; tx_ready stays 1.
- Abort: cs_n rises after 5 sclk rising edges -> one abort pulse, no rx_valid, rx_data keeps previous 8'h3C, miso_oe=0.
- Load collision: tx_load while tx_ready=0 with a different value -> ignored; the original word is transmitted.
- Reset mid-frame: assert rst after 3 bits -> all outputs at reset values within the same cycle. The next full frame, 8'hC3, is received correctly with rx_data=8'hC3.
